// File: rtl/input_cond_pkg.sv
// Shared types for the input conditioner.
//   cond_mode_t  : per-channel edge mode (RISE, FALL, BOTH, NONE)
//   cond_state_t : per-channel event FSM state
//   max2()       : constant helper used to size counters
package input_cond_pkg;

    typedef enum logic [1:0] {
        RISE = 2'd0,
        FALL = 2'd1,
        BOTH = 2'd2,
        NONE = 2'd3
    } cond_mode_t;

    typedef enum logic [1:0] {
        LOCKED,
        RELEASED,
        HELD,
        REPEATING
    } cond_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/input_conditioner_ch.sv
// One conditioner channel: synchroniser, debounce filter, edge detector and
// auto-repeat generator.
// Ports:
//   Clock  in   clock, all state on posedge
//   Reset  in   synchronous, active-high
//   in     in   raw asynchronous input
//   mode   in   edge mode for this channel
//   level  out  debounced level
//   pulse  out  one-cycle event strobe (registered)
module input_conditioner_ch
    import input_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 50,
    parameter int REPEAT_PERIOD   = 10
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       in,
    input  cond_mode_t mode,
    output logic       level,
    output logic       pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_W = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CNT_W-1:0]       cnt_q;
    logic                   toggle, rise_ev, fall_ev;
    logic                   rise_en, fall_en, rpt_en;
    cond_state_t            state_q, state_d;
    logic [RPT_W-1:0]       rpt_q, rpt_d;
    logic                   pulse_d;

    // Synchroniser shift chain; s is the last stage.
    always_ff @(posedge Clock) begin
        if (Reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], in};
    end
    assign s = sync_q[SYNC_STAGES-1];

    // Level flips only after DEBOUNCE_CYCLES consecutive mismatches.
    assign toggle  = (s != level) && (cnt_q == CNT_LAST);
    assign rise_ev = toggle & ~level;
    assign fall_ev = toggle &  level;

    // Reset leaves level high so a key held through reset looks already held.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            level <= 1'b1;
            cnt_q <= '0;
        end else if (toggle) begin
            level <= ~level;
            cnt_q <= '0;
        end else if (s != level) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    assign rise_en = (mode == RISE) || (mode == BOTH);
    assign fall_en = (mode == FALL) || (mode == BOTH);
    assign rpt_en  = (REPEAT_EN != 0) && rise_en;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= LOCKED;
            rpt_q   <= '0;
            pulse   <= 1'b0;
        end else begin
            state_q <= state_d;
            rpt_q   <= rpt_d;
            pulse   <= pulse_d;
        end
    end

    // Edge pulses are computed from the toggle condition so they land on the
    // same edge as the level change. Fall is tested first, so it wins over a
    // repeat due on the same edge. rpt saturates at its target so a mode change
    // mid-hold takes effect on the next edge instead of waiting for a wrap.
    always_comb begin
        state_d = state_q;
        rpt_d   = rpt_q;
        pulse_d = 1'b0;
        case (state_q)
            LOCKED: begin
                if (fall_ev) state_d = RELEASED;
            end
            RELEASED: begin
                if (rise_ev) begin
                    state_d = HELD;
                    rpt_d   = '0;
                    pulse_d = rise_en;
                end
            end
            HELD: begin
                if (fall_ev) begin
                    state_d = RELEASED;
                    pulse_d = fall_en;
                end else if (rpt_q == DLY_LAST) begin
                    if (rpt_en) begin
                        state_d = REPEATING;
                        rpt_d   = '0;
                        pulse_d = 1'b1;
                    end
                end else begin
                    rpt_d = rpt_q + 1'b1;
                end
            end
            REPEATING: begin
                if (fall_ev) begin
                    state_d = RELEASED;
                    pulse_d = fall_en;
                end else if (rpt_q >= PER_LAST) begin
                    if (rpt_en) begin
                        rpt_d   = '0;
                        pulse_d = 1'b1;
                    end
                end else begin
                    rpt_d = rpt_q + 1'b1;
                end
            end
            default: state_d = LOCKED;
        endcase
    end

endmodule

// File: rtl/input_conditioner.sv
// N-channel input conditioner: clean debounced levels plus one-cycle event
// pulses for raw asynchronous inputs (keys, switches, GPIO).
// Ports:
//   Clock  in   single clock, posedge
//   Reset  in   synchronous, active-high
//   in     in   [N_CH]     raw inputs
//   mode   in   [N_CH][2]  per-channel edge mode (cond_mode_t encoding)
//   level  out  [N_CH]     debounced levels
//   pulse  out  [N_CH]     one-cycle event strobes
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 50,
    parameter int REPEAT_PERIOD   = 10
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [N_CH-1:0]      in,
    input  logic [N_CH-1:0][1:0] mode,
    output logic [N_CH-1:0]      level,
    output logic [N_CH-1:0]      pulse
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        input_conditioner_ch #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_EN      (REPEAT_EN),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .Clock(Clock),
            .Reset(Reset),
            .in   (in[i]),
            .mode (cond_mode_t'(mode[i])),
            .level(level[i]),
            .pulse(pulse[i])
        );
    end

endmodule
